// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//
// Purpose
//   Owns the program counter and drives a synchronous-read instruction memory.
//   The memory returns data one cycle after the address is presented. Each
//   fetched word is handed to the decoder with its PC over a valid/ready
//   handshake.
//
//   A 2-entry buffer holds words the decoder has not yet taken. A word that
//   returns from memory while the buffer is empty is presented to the decoder
//   in the same cycle. This gives one cycle from request to valid. If the
//   decoder does not take that word, it is written into the buffer.
//
//   A redirect does three things:
//     - clears the buffer,
//     - discards the word returning in that cycle,
//     - reloads the PC with the target.
//   The first request to the target is issued in the next cycle.
//
// Ports
//   i_clk, i_rst_n          clock; asynchronous active-low reset
//   i_en                    fetch enable (gates new requests only)
//   o_imem_req/o_imem_addr  memory read strobe and byte address
//   i_imem_rdata            word for the address requested last cycle
//   i_redirect_valid/_pc    restart fetch at the target (bits [1:0] ignored)
//   o_instr_valid/o_instr/o_instr_pc   head of the fetch stream
//   i_dec_ready             decoder takes the head this cycle
// -----------------------------------------------------------------------------
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_instr_valid,
    input  logic        i_dec_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc
);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t      state_reg;
    state_t      state_next;
    state_t      state;

    logic [31:0] pc_reg;
    logic        inflight_reg;
    logic [31:0] inflight_pc_reg;
    logic [1:0]  count_reg;
    logic [31:0] buf_instr_reg [2];
    logic [31:0] buf_pc_reg    [2];

    logic        buf_nonempty;
    logic        instr_valid;
    logic        pop;
    logic        buf_pop;
    logic        push;
    logic        issue;
    logic [2:0]  occupancy;
    logic [1:0]  wr_idx;

    // A redirect puts the FSM in FLUSH for the cycle in which it is asserted.
    // No request is made in that cycle. Back-to-back redirects keep it in
    // FLUSH. The registered state returns to RUN afterwards, so the target is
    // requested on the very next cycle.
    always_comb begin
        state      = i_redirect_valid ? FLUSH : state_reg;
        state_next = RUN;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     state_next = RUN;
            FLUSH:   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        buf_nonempty = (count_reg != 2'd0);
        // Visible entries are the buffered words plus the word returning now.
        instr_valid  = buf_nonempty || inflight_reg;
        pop          = instr_valid && i_dec_ready;
        buf_pop      = pop && buf_nonempty;
        // A returning word is written to the buffer unless one of these holds:
        //   - a redirect discards it,
        //   - it was presented straight to the decoder and taken.
        push         = inflight_reg && !i_redirect_valid && !(pop && !buf_nonempty);
        // Occupancy after this cycle's pop. A new request is allowed only if
        // its returning word will still fit.
        occupancy    = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
        issue        = (state == RUN) && i_en && (occupancy <= 3'd1);
        wr_idx       = count_reg - {1'b0, buf_pop};
    end

    assign o_imem_req    = issue;
    assign o_imem_addr   = pc_reg;
    assign o_instr_valid = instr_valid;
    assign o_instr       = !instr_valid ? 32'h0 :
                           (buf_nonempty ? buf_instr_reg[0] : i_imem_rdata);
    assign o_instr_pc    = !instr_valid ? 32'h0 :
                           (buf_nonempty ? buf_pc_reg[0] : inflight_pc_reg);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_reg          <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= 32'h0;
        end else if (i_redirect_valid) begin
            pc_reg          <= {i_redirect_pc[31:2], 2'b00};
            inflight_reg    <= 1'b0;
        end else if (issue) begin
            pc_reg          <= pc_reg + PC_STEP;
            inflight_reg    <= 1'b1;
            inflight_pc_reg <= pc_reg;
        end else begin
            inflight_reg    <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_reg <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_instr_reg[i] <= 32'h0;
                buf_pc_reg[i]    <= 32'h0;
            end
        end else if (i_redirect_valid) begin
            count_reg <= 2'd0;
        end else begin
            count_reg <= count_reg - {1'b0, buf_pop} + {1'b0, push};
            if (buf_pop) begin
                buf_instr_reg[0] <= buf_instr_reg[1];
                buf_pc_reg[0]    <= buf_pc_reg[1];
            end
            // This write comes after the shift. When a pop and a push happen
            // together with one entry held, the new word replaces the old head.
            if (push) begin
                buf_instr_reg[wr_idx[0]] <= i_imem_rdata;
                buf_pc_reg[wr_idx[0]]    <= inflight_pc_reg;
            end
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_fetch_controller
//
// Drives the fetch controller with per-cycle directed vectors and compares
// its outputs against hand-computed values. The vectors cover:
//   - streaming,
//   - back-pressure,
//   - redirect while buffered,
//   - back-to-back redirects,
//   - enable gating with PC wrap.
// A hand-written sequence covers an asynchronous reset in mid-stream.
//
// The memory model returns word_of(addr) one cycle after a request. This
// makes each word distinct from its address, so an instr/pc mix-up is seen.
// -----------------------------------------------------------------------------
module tb_fetch_controller;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        dec_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int checks = 0;
    int errors = 0;

    fetch_controller dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_en             (en),
        .o_imem_req       (imem_req),
        .o_imem_addr      (imem_addr),
        .i_imem_rdata     (imem_rdata),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_instr_valid    (instr_valid),
        .i_dec_ready      (dec_ready),
        .o_instr          (instr),
        .o_instr_pc       (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h1234_5000;
    endfunction

    // Synchronous-read memory. The word is valid in the cycle after the request.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? word_of(imem_addr) : 32'hDEAD_BEEF;
    end

    // Buffer occupancy must never exceed two entries.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert (dut.count_reg <= 2'd2)
            else begin
                errors++;
                $display("FAIL occupancy got %0d want <=2", dut.count_reg);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    typedef struct {
        bit          rst;      // pulse reset before this vector (vector = cycle 0)
        bit          en;
        bit          rdy;
        bit          rv;
        logic [31:0] rpc;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rst, bit e, bit r, bit rv, logic [31:0] rpc,
                                bit q, logic [31:0] a, bit v, logic [31:0] p);
        vec_t t;
        t.rst = rst; t.en = e; t.rdy = r; t.rv = rv; t.rpc = rpc;
        t.exp_req = q; t.exp_addr = a; t.exp_valid = v; t.exp_pc = p;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input bit q, input logic [31:0] a,
                                 input bit v, input logic [31:0] p);
        chk({tag, ".req"},   {31'h0, imem_req},    {31'h0, q});
        chk({tag, ".addr"},  imem_addr,            a);
        chk({tag, ".valid"}, {31'h0, instr_valid}, {31'h0, v});
        chk({tag, ".pc"},    instr_pc,             v ? p : 32'h0);
        chk({tag, ".instr"}, instr,                v ? word_of(p) : 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        #1;
        check_outputs("reset", 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic apply(input int idx, input vec_t t);
        if (t.rst) do_reset();
        @(negedge clk);
        en = t.en; dec_ready = t.rdy; redirect_valid = t.rv; redirect_pc = t.rpc;
        #1;
        $display("vec %0d: req=%0b addr=%h valid=%0b pc=%h instr=%h",
                 idx, imem_req, imem_addr, instr_valid, instr_pc, instr);
        check_outputs($sformatf("vec%0d", idx), t.exp_req, t.exp_addr, t.exp_valid, t.exp_pc);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; dec_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;

        // Stream: request from cycle 1, valid from cycle 2, one per cycle.
        //  rst e  r  rv rpc     req addr          v  pc
        add(1, 1, 1, 0, 32'h0,  0, 32'h0000_0000, 0, 32'h0);
        add(0, 1, 1, 0, 32'h0,  1, 32'h0000_0000, 0, 32'h0);
        add(0, 1, 1, 0, 32'h0,  1, 32'h0000_0004, 1, 32'h0000_0000);
        add(0, 1, 1, 0, 32'h0,  1, 32'h0000_0008, 1, 32'h0000_0004);
        add(0, 1, 1, 0, 32'h0,  1, 32'h0000_000C, 1, 32'h0000_0008);
        add(0, 1, 1, 0, 32'h0,  1, 32'h0000_0010, 1, 32'h0000_000C);
        // Back-pressure: ready low for cycles 2..6. Two words are buffered,
        // requests stop and the head holds pc 0. Then 0, 4, 8 follow with no gap.
        add(1, 1, 1, 0, 32'h0,  0, 32'h0000_0000, 0, 32'h0);
        add(0, 1, 1, 0, 32'h0,  1, 32'h0000_0000, 0, 32'h0);
        add(0, 1, 0, 0, 32'h0,  1, 32'h0000_0004, 1, 32'h0000_0000);
        add(0, 1, 0, 0, 32'h0,  0, 32'h0000_0008, 1, 32'h0000_0000);
        add(0, 1, 0, 0, 32'h0,  0, 32'h0000_0008, 1, 32'h0000_0000);
        add(0, 1, 0, 0, 32'h0,  0, 32'h0000_0008, 1, 32'h0000_0000);
        add(0, 1, 0, 0, 32'h0,  0, 32'h0000_0008, 1, 32'h0000_0000);
        add(0, 1, 1, 0, 32'h0,  1, 32'h0000_0008, 1, 32'h0000_0000);
        add(0, 1, 1, 0, 32'h0,  1, 32'h0000_000C, 1, 32'h0000_0004);
        add(0, 1, 1, 0, 32'h0,  1, 32'h0000_0010, 1, 32'h0000_0008);
        add(0, 1, 1, 0, 32'h0,  1, 32'h0000_0014, 1, 32'h0000_000C);
        // Redirect with 8 buffered and 12 returning. The redirect target 0x102
        // has bit 1 set so the masking of the low bits is exercised.
        add(1, 1, 1, 0, 32'h0,  0, 32'h0000_0000, 0, 32'h0);            // c0
        add(0, 1, 1, 0, 32'h0,  1, 32'h0000_0000, 0, 32'h0);            // c1
        add(0, 1, 1, 0, 32'h0,  1, 32'h0000_0004, 1, 32'h0000_0000);    // c2
        add(0, 1, 1, 0, 32'h0,  1, 32'h0000_0008, 1, 32'h0000_0004);    // c3
        add(0, 1, 0, 0, 32'h0,  1, 32'h0000_000C, 1, 32'h0000_0008);    // c4 hold 8
        add(0, 1, 1, 1, 32'h102, 0, 32'h0000_0010, 1, 32'h0000_0008);   // c5 redirect, 8 taken
        add(0, 1, 1, 0, 32'h0,  1, 32'h0000_0100, 0, 32'h0);            // c6
        add(0, 1, 1, 0, 32'h0,  1, 32'h0000_0104, 1, 32'h0000_0100);    // c7
        // Back-to-back redirects to 0x40 then 0x80: nothing from 0x40 is fetched.
        add(0, 1, 1, 1, 32'h40, 0, 32'h0000_0108, 1, 32'h0000_0104);    // c8
        add(0, 1, 1, 1, 32'h80, 0, 32'h0000_0040, 0, 32'h0);            // c9
        add(0, 1, 1, 0, 32'h0,  1, 32'h0000_0080, 0, 32'h0);            // c10
        add(0, 1, 1, 0, 32'h0,  1, 32'h0000_0084, 1, 32'h0000_0080);    // c11
        add(0, 1, 1, 0, 32'h0,  1, 32'h0000_0088, 1, 32'h0000_0084);    // c12
        // Redirect near the top of the address space, then enable low for 3
        // cycles. Delivery order: FFFF_FFF8, FFFF_FFFC, 0.
        add(0, 1, 1, 1, 32'hFFFF_FFF8, 0, 32'h0000_008C, 1, 32'h0000_0088); // c13
        add(0, 1, 1, 0, 32'h0,  1, 32'hFFFF_FFF8, 0, 32'h0);            // c14
        add(0, 1, 1, 0, 32'h0,  1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8);    // c15
        add(0, 0, 1, 0, 32'h0,  0, 32'h0000_0000, 1, 32'hFFFF_FFFC);    // c16
        add(0, 0, 1, 0, 32'h0,  0, 32'h0000_0000, 0, 32'h0);            // c17
        add(0, 0, 1, 0, 32'h0,  0, 32'h0000_0000, 0, 32'h0);            // c18
        add(0, 1, 1, 0, 32'h0,  1, 32'h0000_0000, 0, 32'h0);            // c19
        add(0, 1, 1, 0, 32'h0,  1, 32'h0000_0004, 1, 32'h0000_0000);    // c20
        add(0, 1, 1, 0, 32'h0,  1, 32'h0000_0008, 1, 32'h0000_0004);    // c21

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // Async reset mid-stream with two words buffered. Outputs must drop
        // immediately, without waiting for a clock edge.
        do_reset();
        @(negedge clk); en = 1'b1; dec_ready = 1'b1;     // c0
        @(negedge clk);                                  // c1
        @(negedge clk); dec_ready = 1'b0;                // c2
        @(negedge clk);                                  // c3
        @(negedge clk); #1;                              // c4: 0 and 4 buffered
        check_outputs("pre_areset", 1'b0, 32'h8, 1'b1, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        $display("areset: req=%0b addr=%h valid=%0b pc=%h instr=%h",
                 imem_req, imem_addr, instr_valid, instr_pc, instr);
        check_outputs("areset", 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        en = 1'b1; dec_ready = 1'b1;
        @(negedge clk); #1;
        check_outputs("restart_c0", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk); #1;
        check_outputs("restart_c1", 1'b1, 32'h0, 1'b0, 32'h0);
        @(negedge clk); #1;
        check_outputs("restart_c2", 1'b1, 32'h4, 1'b1, 32'h0);
        @(negedge clk); #1;
        check_outputs("restart_c3", 1'b1, 32'h8, 1'b1, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
